// File: rtl/contador_gray_param_pkg.sv
// contador_gray_param_pkg: shared width/saturation defaults and range limits for the Gray counter and its bench
package contador_gray_param_pkg;
  localparam int DEF_WIDTH = 5;
  localparam int DEF_SATURATE = 0;
  localparam int MIN_WIDTH = 2;
  localparam int MAX_WIDTH = 16;
  typedef enum logic {DIR_DOWN = 1'b0, DIR_UP = 1'b1} dir_e;
endpackage

// File: rtl/contador_gray_param_if.sv
// contador_gray_param_if: control inputs and count outputs of the Gray counter
interface contador_gray_param_if
  import contador_gray_param_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic             enable;
  logic             up_down;
  logic             load;
  logic [WIDTH-1:0] valor_carga;
  logic [WIDTH-1:0] salida_gray;
  logic [WIDTH-1:0] salida_bin;
  logic             terminal;
  logic             vuelta;
  modport master (
    output enable, up_down, load, valor_carga,
    input  salida_gray, salida_bin, terminal, vuelta
  );
  modport slave (
    input  enable, up_down, load, valor_carga,
    output salida_gray, salida_bin, terminal, vuelta
  );
endinterface

// File: rtl/contador_gray_param_bin_a_gray.sv
// bin_a_gray: combinational binary-to-Gray conversion
module bin_a_gray #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] bin_i,
  output logic [WIDTH-1:0] gray_o
);
  assign gray_o = bin_i ^ (bin_i >> 1);
endmodule

// File: rtl/contador_gray_param.sv
// contador_gray_param: loadable up/down binary counter with registered Gray output, wrap pulse and optional saturation
module contador_gray_param
  import contador_gray_param_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SATURATE = DEF_SATURATE
) (
  input logic clk,
  input logic reset,
  contador_gray_param_if.slave bus
);
  logic [WIDTH-1:0] bin_q, bin_d, gray_q, gray_d;
  logic             vuelta_q, vuelta_d;
  logic             terminal, step;
  assign terminal = (bus.up_down == DIR_UP) ? &bin_q : ~|bin_q;
  // a saturating counter simply refuses to step off either end
  assign step = bus.enable && !((SATURATE != 0) && terminal);
  always_comb begin
    bin_d    = bus.load ? bus.valor_carga
             : step ? ((bus.up_down == DIR_UP) ? bin_q + 1'b1 : bin_q - 1'b1)
             : bin_q;
    vuelta_d = !bus.load && step && terminal;
  end
  bin_a_gray #(.WIDTH(WIDTH)) u_bin_a_gray (
    .bin_i (bin_d),
    .gray_o(gray_d)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      bin_q    <= '0;
      gray_q   <= '0;
      vuelta_q <= 1'b0;
    end else begin
      bin_q    <= bin_d;
      gray_q   <= gray_d;
      vuelta_q <= vuelta_d;
    end
  end
  assign bus.salida_bin  = bin_q;
  assign bus.salida_gray = gray_q;
  assign bus.vuelta      = vuelta_q;
  assign bus.terminal    = terminal;
endmodule
